scc_bus_interface: RTL
======================

// Module: scc_bus_interface
// PURPOSE
//  Upstream front end of scc_register: samples asynchronous MSX cartridge slot strobes, address and data into clk.
//  Turns each bus cycle into single-cycle wrreq/rdreq pulses, wr_active/rd_active levels and stable address/wrdata.
//  On reads it waits a fixed latency, then drives the returned rddata onto the slot data bus.
//  It does not drive the bus when external memory is selected.
// PARAMETERS
//  RD_LATENCY  4  clk cycles from the rdreq pulse to rddata capture; legal range 2..15
// PORTS
//  clk                 in   1   system clock
//  reset               in   1   synchronous, active-high reset
//  slot_nsltsl         in   1   slot select, active low, asynchronous
//  slot_nrd            in   1   read strobe, active low, asynchronous
//  slot_nwr            in   1   write strobe, active low, asynchronous
//  slot_a              in   15  CPU address A14..A0
//  slot_d              in   8   CPU write data
//  slot_d_out          out  8   read data driven to the slot
//  slot_d_oe           out  1   slot data output enable
//  slot_nwait          out  1   Z80 WAIT, active low
//  wrreq               out  1   one-cycle write request
//  rdreq               out  1   one-cycle read request
//  wr_active           out  1   write cycle in progress
//  rd_active           out  1   read cycle in progress
//  address             out  15  latched cycle address
//  wrdata              out  8   latched write data
//  rddata              in   8   read data returned by scc_register
//  ext_memory_nactive  in   1   0 = external memory serves this access
// BEHAVIOUR
//  - Input path: slot_nsltsl/nrd/nwr/a/d each pass through a 2-FF pipeline (_s signals); stage 3 holds the previous strobe values for edge detection.
//  - Reset: state=IDLE, counter=0, wrreq=rdreq=wr_active=rd_active=0, address=0, wrdata=0.
//    Also at reset: slot_d_out=0, slot_d_oe=0, slot_nwait=1, synchronizer FFs=1 (strobes inactive).
//    A reset asserted mid-cycle wins unconditionally; after release the block waits in IDLE for the next falling strobe.
//  - Request condition, evaluated in IDLE only:
//    - rd_start = nsltsl_s=0 & nrd_s falls & nwr_s=1.
//    - wr_start = nsltsl_s=0 & nwr_s falls & nrd_s=1.
//    - Both strobes low together is illegal: it is ignored and the block stays in IDLE.
//  - FSM states:
//    - IDLE -> WRITE on wr_start: wrreq=1 for exactly that one cycle. address<=a_s, wrdata<=d_s.
//    - IDLE -> READ on rd_start: rdreq=1 for exactly that one cycle. address<=a_s, counter<=RD_LATENCY-1.
//    - READ: rd_active=1; counter decrements each cycle.
//      - At counter=0: capture rddata into slot_d_out, go to READ_HOLD.
//      - If nrd_s=1 or nsltsl_s=1 first: abort to RECOVER with no data driven.
//    - READ_HOLD: rd_active=1; slot_d_oe=ext_memory_nactive. Exit to RECOVER when nrd_s=1 or nsltsl_s=1.
//    - WRITE: wr_active=1. Exit to RECOVER when nwr_s=1 or nsltsl_s=1.
//    - RECOVER: one cycle with all active/oe outputs low, then IDLE. This prevents a held strobe from retriggering.
//  - All outputs are registered. address/wrdata stay constant from the request cycle until the next request.
//  - Counter is 4 bits and never wraps: it is loaded only on entry to READ.
//  - slot_d_oe is low in every state other than READ_HOLD.
// CONFIGURATION
//  - SCC_BUS_WAIT_EN defined:
//    - slot_nwait is registered 0 from the cycle after rd_start until the READ->READ_HOLD transition, and 1 otherwise.
//    - Writes never assert WAIT.
//  - SCC_BUS_WAIT_EN undefined: slot_nwait is constant 1. The host must supply enough wait states itself.
// STRUCTURE
//  - Shared package/include scc_bus_pkg: state encodings (IDLE, READ, READ_HOLD, WRITE, RECOVER, 3-bit) and RD_LATENCY default.
//  - Sub-module scc_sync2: a parameter-width 2-FF synchronizer with reset value, instantiated for the strobes and for the a/d buses.
// TESTING
//  1. Write: a=7'h...=15'h1800 (9800h), d=8'h5A, nwr low 6 clk.
//     -> wrreq pulse width 1; address=15'h1800; wrdata=8'h5A; wr_active high until nwr_s rises; no WAIT.
//  2. Read, RD_LATENCY=4, rddata=8'hC3, ext_memory_nactive=1, nrd low 10 clk.
//     -> rdreq 1 cycle; slot_nwait low 4 cycles (WAIT_EN); slot_d_out=8'hC3 with oe=1 until nrd_s rises.
//  3. Read with ext_memory_nactive=0.
//     -> rdreq/rd_active behave as in test 2; slot_d_oe stays 0 throughout.
//  4. nrd released 2 clk after the falling edge (RD_LATENCY=4).
//     -> abort to RECOVER; slot_d_oe never asserts; slot_nwait returns to 1.
//  5. nrd and nwr fall together; separately, nsltsl=1 with nwr falling.
//     -> no wrreq/rdreq, state stays IDLE.
//  6. reset asserted during READ_HOLD.
//     -> next cycle all outputs at reset values; a subsequent write produces exactly one wrreq.

Source files
------------

// File: rtl/scc_bus_pkg.sv
// ============================================================================
// Module   : scc_bus_pkg
// Brief    : Shared state encoding and defaults for the SCC slot bus front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package scc_bus_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ      = 3'd1,
        READ_HOLD = 3'd2,
        WRITE     = 3'd3,
        RECOVER   = 3'd4
    } scc_bus_state_t;

    localparam int unsigned c_rd_latency_default = 4;
    localparam int          c_cnt_w              = 4;

endpackage

`default_nettype wire

// File: rtl/scc_sync2.sv
// ============================================================================
// Module   : scc_sync2
// Brief    : Parameter-width two-flop synchronizer with a configurable reset value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scc_sync2 #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/scc_bus_interface.sv
// ============================================================================
// Module   : scc_bus_interface
// Brief    : MSX slot front end for scc_register: synchronizes the slot strobes,
//            turns bus cycles into request pulses and drives read data back.
//            Optional macro SCC_BUS_WAIT_EN enables Z80 WAIT during read latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scc_bus_interface
    import scc_bus_pkg::*;
#(
    parameter int unsigned RD_LATENCY = c_rd_latency_default   // legal 2..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        slot_nsltsl,
    input  logic        slot_nrd,
    input  logic        slot_nwr,
    input  logic [14:0] slot_a,
    input  logic [7:0]  slot_d,
    output logic [7:0]  slot_d_out,
    output logic        slot_d_oe,
    output logic        slot_nwait,
    output logic        wrreq,
    output logic        rdreq,
    output logic        wr_active,
    output logic        rd_active,
    output logic [14:0] address,
    output logic [7:0]  wrdata,
    input  logic [7:0]  rddata,
    input  logic        ext_memory_nactive
);

    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(RD_LATENCY - 1);

    logic [2:0]  w_strb_s;
    logic [22:0] w_bus_s;
    logic        w_nsltsl_s;
    logic        w_nrd_s;
    logic        w_nwr_s;
    logic [14:0] w_a_s;
    logic [7:0]  w_d_s;

    // Strobes reset to the inactive level so release of reset cannot fake an edge.
    scc_sync2 #(
        .WIDTH     (3),
        .RESET_VAL (3'b111)
    ) u_sync_strb (
        .clk   (clk),
        .reset (reset),
        .d     ({slot_nsltsl, slot_nrd, slot_nwr}),
        .q     (w_strb_s)
    );

    scc_sync2 #(
        .WIDTH     (23),
        .RESET_VAL (23'd0)
    ) u_sync_bus (
        .clk   (clk),
        .reset (reset),
        .d     ({slot_a, slot_d}),
        .q     (w_bus_s)
    );

    assign w_nsltsl_s = w_strb_s[2];
    assign w_nrd_s    = w_strb_s[1];
    assign w_nwr_s    = w_strb_s[0];
    assign w_a_s      = w_bus_s[22:8];
    assign w_d_s      = w_bus_s[7:0];

    logic r_nrd_d;
    logic r_nwr_d;
    logic w_rd_start;
    logic w_wr_start;

    // A cycle with both strobes low satisfies neither start term and is ignored.
    assign w_rd_start = ~w_nsltsl_s & r_nrd_d & ~w_nrd_s & w_nwr_s;
    assign w_wr_start = ~w_nsltsl_s & r_nwr_d & ~w_nwr_s & w_nrd_s;

    scc_bus_state_t     r_state;
    scc_bus_state_t     w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_req_rd;
    logic               w_req_wr;
    logic               w_capture;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req_rd    = 1'b0;
        w_req_wr    = 1'b0;
        w_capture   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_rd_start) begin
                    w_state_nxt = READ;
                    w_cnt_nxt   = c_cnt_load;
                    w_req_rd    = 1'b1;
                end else if (w_wr_start) begin
                    w_state_nxt = WRITE;
                    w_req_wr    = 1'b1;
                end
            end
            READ: begin
                // A released strobe takes priority over a data capture in the same cycle.
                if (w_nrd_s | w_nsltsl_s) begin
                    w_state_nxt = RECOVER;
                end else if (r_cnt == '0) begin
                    w_state_nxt = READ_HOLD;
                    w_capture   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            READ_HOLD: begin
                if (w_nrd_s | w_nsltsl_s) begin
                    w_state_nxt = RECOVER;
                end
            end
            WRITE: begin
                if (w_nwr_s | w_nsltsl_s) begin
                    w_state_nxt = RECOVER;
                end
            end
            RECOVER: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    logic        r_wrreq;
    logic        r_rdreq;
    logic        r_wr_active;
    logic        r_rd_active;
    logic [14:0] r_addr;
    logic [7:0]  r_wrdata;
    logic [7:0]  r_dout;
    logic        r_oe;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_nrd_d     <= 1'b1;
            r_nwr_d     <= 1'b1;
            r_wrreq     <= 1'b0;
            r_rdreq     <= 1'b0;
            r_wr_active <= 1'b0;
            r_rd_active <= 1'b0;
            r_addr      <= '0;
            r_wrdata    <= '0;
            r_dout      <= '0;
            r_oe        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_nrd_d     <= w_nrd_s;
            r_nwr_d     <= w_nwr_s;
            r_wrreq     <= w_req_wr;
            r_rdreq     <= w_req_rd;
            r_wr_active <= (w_state_nxt == WRITE);
            r_rd_active <= (w_state_nxt == READ) || (w_state_nxt == READ_HOLD);
            r_oe        <= (w_state_nxt == READ_HOLD) && ext_memory_nactive;
            if (w_req_rd | w_req_wr) begin
                r_addr <= w_a_s;
            end
            if (w_req_wr) begin
                r_wrdata <= w_d_s;
            end
            if (w_capture) begin
                r_dout <= rddata;
            end
        end
    end

`ifdef SCC_BUS_WAIT_EN
    logic r_nwait;

    // WAIT covers exactly the cycles spent waiting for read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_nwait <= 1'b1;
        end else begin
            r_nwait <= (w_state_nxt != READ);
        end
    end

    assign slot_nwait = r_nwait;
`else
    assign slot_nwait = 1'b1;
`endif

    assign wrreq      = r_wrreq;
    assign rdreq      = r_rdreq;
    assign wr_active  = r_wr_active;
    assign rd_active  = r_rd_active;
    assign address    = r_addr;
    assign wrdata     = r_wrdata;
    assign slot_d_out = r_dout;
    assign slot_d_oe  = r_oe;

endmodule

`default_nettype wire
